perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_pkg.sv | 37 +++
 rtl/perf_cnt_unit.sv | 47 ++++
 rtl/perf_counter_bank.sv | 79 +++++++
 tb/tb_perf_counter_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank.
// Latency: n/a (types, constants and a pure next-state function only).
// Backpressure: n/a.
// Contents: counter index constants, FSM state encoding, FSM next-state helper.
package perf_pkg;

  // Number of counters held by the bank.
  localparam int NUM_CNT = 4;

  // Counter indices as seen by cnt_sel / clr_mask / cnt_ovf.
  localparam logic [1:0] CNT_CYCLE  = 2'd0;  // every cycle while running
  localparam logic [1:0] CNT_INSTR  = 2'd1;  // inst_retire
  localparam logic [1:0] CNT_STALL  = 2'd2;  // pipe_stall
  localparam logic [1:0] CNT_BRANCH = 2'd3;  // br_taken

  // Run-control FSM encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } perf_state_e;

  // Next state of the run-control FSM. Stop wins over start in every state,
  // so a simultaneous start+stop always lands in IDLE.
  function automatic perf_state_e fsm_next(input perf_state_e cur,
                                           input logic        start,
                                           input logic        stop);
    perf_state_e nxt;
    nxt = cur;
    if (stop) begin
      nxt = ST_IDLE;
    end else if (start) begin
      nxt = ST_RUN;
    end
    return nxt;
  endfunction

endpackage : perf_pkg

// File: rtl/perf_cnt_unit.sv
// One event counter with sticky overflow, wrap or saturate on overflow.
// Latency: value/ovf update one clock after inc/clr are sampled.
// Backpressure: none; at most one increment accepted per cycle, clr wins over inc.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one to the counter at the next edge
//   clr        : zero the counter and its overflow flag at the next edge
//   value      : registered counter value
//   ovf        : sticky overflow flag, set when an increment hits all-ones
module perf_cnt_unit
  import perf_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  logic at_max;

  assign at_max = (value == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      // Clear takes precedence over a same-cycle increment.
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (at_max) begin
        // Overflow: saturating counters hold all-ones, wrapping ones roll to 0.
        value <= SATURATE ? value : '0;
        ovf   <= 1'b1;
      end else begin
        value <= value + CNT_W'(1);
      end
    end
  end

endmodule : perf_cnt_unit

// File: rtl/perf_counter_bank.sv
// Bank of four performance counters (CYCLE, INSTR, STALL, BRANCH) under start/stop control.
// Latency: counts land one clock after the event; perf_cnt read path is combinational (zero cycles).
// Backpressure: none; every qualified event is counted, at most one per counter per cycle.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   cnt_start, cnt_stop    : run-control pulses, stop wins when both are high
//   clr_mask[3:0]          : per-counter synchronous clear of value and overflow
//   inst_retire, pipe_stall, br_taken : event inputs for counters 1..3
//   cnt_sel[1:0]           : counter index read out on perf_cnt
//   perf_cnt[CNT_W-1:0]    : selected counter value (registered value, muxed combinationally)
//   cnt_ovf[3:0]           : sticky per-counter overflow flags
//   running                : high while the FSM is in RUN
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_start,
  input  logic             cnt_stop,
  input  logic [3:0]       clr_mask,
  input  logic             inst_retire,
  input  logic             pipe_stall,
  input  logic             br_taken,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] perf_cnt,
  output logic [3:0]       cnt_ovf,
  output logic             running
);

  perf_state_e          state;
  logic [NUM_CNT-1:0]   cnt_inc;
  logic [CNT_W-1:0]     cnt_val [NUM_CNT];

  // Run-control FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= fsm_next(state, cnt_start, cnt_stop);
    end
  end

  assign running = (state == ST_RUN);

  // Increments are qualified by the registered state, not the next state:
  // the cycle that samples cnt_start is not counted, the cycle that samples
  // cnt_stop while running is.
  always_comb begin
    cnt_inc = '0;
    if (state == ST_RUN) begin
      cnt_inc[CNT_CYCLE]  = 1'b1;
      cnt_inc[CNT_INSTR]  = inst_retire;
      cnt_inc[CNT_STALL]  = pipe_stall;
      cnt_inc[CNT_BRANCH] = br_taken;
    end
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_cnt_unit #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc[i]),
      .clr   (clr_mask[i]),
      .value (cnt_val[i]),
      .ovf   (cnt_ovf[i])
    );
  end

  // Readout shows the registered value, i.e. the pre-increment value in a
  // cycle where the selected counter is also incrementing.
  assign perf_cnt = cnt_val[cnt_sel];

endmodule : perf_counter_bank

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: one wrapping and one saturating instance share stimulus.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_start, cnt_stop;
  logic [3:0]  clr_mask;
  logic        inst_retire, pipe_stall, br_taken;
  logic [1:0]  cnt_sel;

  logic [15:0] perf_cnt_w, perf_cnt_s;
  logic [3:0]  ovf_w, ovf_s;
  logic        running_w, running_s;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.CNT_W(16), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .cnt_start(cnt_start), .cnt_stop(cnt_stop),
    .clr_mask(clr_mask), .inst_retire(inst_retire), .pipe_stall(pipe_stall),
    .br_taken(br_taken), .cnt_sel(cnt_sel), .perf_cnt(perf_cnt_w),
    .cnt_ovf(ovf_w), .running(running_w)
  );

  perf_counter_bank #(.CNT_W(16), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .cnt_start(cnt_start), .cnt_stop(cnt_stop),
    .clr_mask(clr_mask), .inst_retire(inst_retire), .pipe_stall(pipe_stall),
    .br_taken(br_taken), .cnt_sel(cnt_sel), .perf_cnt(perf_cnt_s),
    .cnt_ovf(ovf_s), .running(running_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Select a counter and compare both instances' readouts.
  task automatic rd(input string tag, input logic [1:0] sel,
                    input logic [15:0] exp_w, input logic [15:0] exp_s);
    cnt_sel = sel;
    #1;
    chk({tag, "_wrap"}, {16'h0, perf_cnt_w}, {16'h0, exp_w});
    chk({tag, "_sat"},  {16'h0, perf_cnt_s}, {16'h0, exp_s});
  endtask

  task automatic idle_inputs();
    cnt_start   = 1'b0;
    cnt_stop    = 1'b0;
    clr_mask    = 4'b0000;
    inst_retire = 1'b0;
    pipe_stall  = 1'b0;
    br_taken    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n   = 1'b0;
    cnt_sel = 2'd0;
    idle_inputs();

    // Reset state, observed before any clock edge.
    #3;
    chk("rst_perf_cnt", {16'h0, perf_cnt_w}, 32'h0);
    chk("rst_running",  {31'h0, running_w},  32'h0);
    chk("rst_ovf",      {28'h0, ovf_w},      32'h0);

    // Basic run: start at cycle 0, 10 retires, stop at cycle 20.
    do_reset();
    chk("idle_after_rst", {31'h0, running_w}, 32'h0);
    cnt_start = 1'b1;
    step();
    cnt_start = 1'b0;
    chk("run_after_start", {31'h0, running_w}, 32'h1);
    rd("start_cycle_uncounted", 2'd0, 16'd0, 16'd0);
    for (int i = 1; i <= 20; i++) begin
      inst_retire = (i <= 10);
      cnt_stop    = (i == 20);
      step();
      if (i == 5) rd("cycle_at5", 2'd0, 16'd5, 16'd5);
    end
    idle_inputs();
    chk("stopped", {31'h0, running_w}, 32'h0);
    rd("cycle_total", 2'd0, 16'd20, 16'd20);
    rd("instr_total", 2'd1, 16'd10, 16'd10);
    rd("stall_total", 2'd2, 16'd0, 16'd0);
    step();
    step();
    rd("cycle_frozen", 2'd0, 16'd20, 16'd20);
    rd("instr_reread", 2'd1, 16'd10, 16'd10);

    // Simultaneous start+stop from IDLE stays IDLE.
    do_reset();
    cnt_start = 1'b1;
    cnt_stop  = 1'b1;
    step();
    idle_inputs();
    chk("startstop_idle", {31'h0, running_w}, 32'h0);
    step();
    step();
    rd("startstop_cycle", 2'd0, 16'd0, 16'd0);
    rd("startstop_instr", 2'd1, 16'd0, 16'd0);

    // Simultaneous start+stop from RUN also goes IDLE (that cycle counts).
    cnt_start = 1'b1;
    step();
    cnt_start = 1'b1;
    cnt_stop  = 1'b1;
    step();
    idle_inputs();
    chk("startstop_from_run", {31'h0, running_w}, 32'h0);
    rd("startstop_run_cycle", 2'd0, 16'd1, 16'd1);

    // Clear INSTR in the same cycle as a retire; others continue.
    do_reset();
    cnt_start = 1'b1;
    step();
    cnt_start   = 1'b0;
    inst_retire = 1'b1;
    pipe_stall  = 1'b1;
    br_taken    = 1'b1;
    repeat (4) step();
    rd("pre_clr_instr", 2'd1, 16'd4, 16'd4);
    clr_mask = 4'b0010;
    step();
    clr_mask    = 4'b0000;
    inst_retire = 1'b0;
    pipe_stall  = 1'b0;
    br_taken    = 1'b0;
    rd("clr_instr",  2'd1, 16'd0, 16'd0);
    rd("clr_cycle",  2'd0, 16'd5, 16'd5);
    rd("clr_stall",  2'd2, 16'd5, 16'd5);
    rd("clr_branch", 2'd3, 16'd5, 16'd5);

    // Reset mid-RUN: immediate, without a clock edge.
    do_reset();
    cnt_start = 1'b1;
    step();
    cnt_start = 1'b0;
    repeat (37) step();
    rd("cycle_37", 2'd0, 16'd37, 16'd37);
    chk("running_before_rst", {31'h0, running_w}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    rd("async_rst_cycle", 2'd0, 16'd0, 16'd0);
    chk("async_rst_running", {31'h0, running_w}, 32'h0);
    #1;
    rst_n = 1'b1;
    step();
    step();
    chk("idle_after_release", {31'h0, running_w}, 32'h0);
    rd("no_count_after_release", 2'd0, 16'd0, 16'd0);

    // Overflow: STALL and CYCLE reach 0xFFFF together, then one more increment.
    do_reset();
    cnt_start  = 1'b1;
    pipe_stall = 1'b1;
    step();
    cnt_start = 1'b0;
    repeat (65535) step();
    rd("stall_at_max", 2'd2, 16'hFFFF, 16'hFFFF);
    chk("ovf_before_wrap", {28'h0, ovf_w}, 32'h0);
    step();
    rd("stall_overflow", 2'd2, 16'h0000, 16'hFFFF);
    chk("ovf_wrap", {28'h0, ovf_w}, 32'h5);
    chk("ovf_sat",  {28'h0, ovf_s}, 32'h5);
    step();
    rd("stall_after_ovf", 2'd2, 16'h0001, 16'hFFFF);
    chk("ovf_sticky_wrap", {28'h0, ovf_w}, 32'h5);
    cnt_stop   = 1'b1;
    pipe_stall = 1'b0;
    step();
    cnt_stop = 1'b0;
    rd("cycle_after_stop", 2'd0, 16'h0002, 16'hFFFF);
    clr_mask = 4'b0100;
    step();
    clr_mask = 4'b0000;
    chk("ovf_clr_wrap", {28'h0, ovf_w}, 32'h1);
    chk("ovf_clr_sat",  {28'h0, ovf_s}, 32'h1);
    rd("stall_clr_idle", 2'd2, 16'h0000, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_perf_counter_bank
